manual_order_entry: RTL and testbench
=====================================

Name: manual_order_entry

Overview:
Downstream consumer of the debounced push-button outputs. Converts clean button levels and switch settings into single, well-formed order messages for the order-book input port, using a valid/ready handshake. Provides edge detection, a buy/sell side toggle, field validation, order-ID assignment and overrun/reject accounting, so that operators can inject test orders from board controls.

Parameters:
PRICE_W, 16, width of price field (ticks)
QTY_W, 8, width of quantity field
ID_W, 8, width of order ID; wraps modulo 2^ID_W
MAX_PRICE, 10000, largest accepted price; must be < 2^PRICE_W
CNT_W, 8, width of drop/reject counters

Ports:
clock_in  input  1  system clock
reset_in  input  1  synchronous, active-low reset (0 = reset)
submit_clean  input  1  debounced submit button level
side_clean  input  1  debounced side-toggle button level
sw_price  input  PRICE_W  price switches, sampled on accepted submit edge
sw_qty  input  QTY_W  quantity switches, sampled on accepted submit edge
order_ready  input  1  order-book ready to accept order
order_valid  output  1  order presented
order_side  output  1  0 = buy, 1 = sell
order_price  output  PRICE_W  latched price
order_qty  output  QTY_W  latched quantity
order_id  output  ID_W  ID of presented order
side_sel  output  1  current side selection (LED)
busy  output  1  high while in SEND
reject_pulse  output  1  one-cycle pulse on rejected submit
reject_count  output  CNT_W  saturating count of rejects
drop_count  output  CNT_W  saturating count of submits dropped while busy

Behaviour:
- Reset (reset_in low at a posedge): order_valid=0, busy=0, reject_pulse=0, side_sel=0 (buy), order_side/price/qty=0, order_id=0, next-ID counter=0, both counters=0, FSM=IDLE. Previous-level registers load the current button levels, so a button held through reset produces no edge on release from reset.
- Edge detect: rise = level & ~prev, with prev registered each cycle. A rising edge is one cycle long, regardless of press duration.
- Side toggle: on side rise, side_sel inverts. This occurs in any FSM state and never alters an order already latched.
- FSM states: IDLE, SEND.
- IDLE, submit rise:
  - qty==0 or price>MAX_PRICE: reject_pulse=1 for exactly one cycle, reject_count+1 (saturate at all-ones), stay IDLE.
  - Otherwise: at the same edge, latch sw_price, sw_qty, side_sel (value before any same-cycle toggle), and next-ID into the order_* outputs. Set order_valid=1 and busy=1, then go to SEND.
  - Latency: order_valid is high in the first cycle after the posedge that sampled the rise.
- SEND:
  - order_* outputs are held stable while order_valid=1 and order_ready=0.
  - On a posedge with order_valid & order_ready: transfer completes, order_valid=0, busy=0, next-ID+1 (wraps 2^ID_W-1 -> 0), go to IDLE.
  - order_ready is allowed to already be high when valid rises; this gives a one-cycle valid.
  - A submit rise while in SEND, including the transfer cycle, is dropped. drop_count+1 (saturating). No reject_pulse.
- Validation uses registered-free combinational compare of the switch inputs at the rise cycle. Switches are assumed static to within one cycle of the button; no synchronisation inside this block.
- order_price/qty/side/id retain the last transferred values while idle.
- Reset mid-SEND: the order is abandoned with no transfer, and all state returns to reset values, including ID=0.

Test Plan:
- Reset with submit_clean held 1, release reset, hold 50 cycles -> no order_valid, drop_count=0, reject_count=0.
- sw_price=100, sw_qty=5, side buy, submit rise at cycle N, order_ready=0 until N+4 -> valid from N+1 to N+4 inclusive, fields stable at 100/5/0/id 0; ID becomes 1 after transfer.
- Toggle side once, then submit with order_ready tied 1 -> one-cycle valid, order_side=1, id=1; side and submit rise in the same cycle -> latched side is pre-toggle value, side_sel flips.
- sw_qty=0, then sw_price=10001 -> two single-cycle reject_pulses, reject_count=2, no order_valid.
- Three submit rises while order_ready=0 in SEND -> drop_count=3, latched fields unchanged; 300 rejects -> reject_count saturates at 255.
- 256 accepted orders -> IDs 0..255, then 0. Assert reset mid-SEND -> valid=0 next cycle, id reset to 0.

Source files
------------

// File: rtl/manual_order_entry.sv
// Turns debounced button levels and switch settings into single order messages
// on a valid/ready port, with side toggle, field validation, ID assignment and reject/drop counters.
module manual_order_entry #(
    parameter int unsigned PRICE_W   = 16,
    parameter int unsigned QTY_W     = 8,
    parameter int unsigned ID_W      = 8,
    parameter int unsigned MAX_PRICE = 10000,
    parameter int unsigned CNT_W     = 8
) (
    input  logic               clock_in,
    input  logic               reset_in,
    input  logic               submit_clean,
    input  logic               side_clean,
    input  logic [PRICE_W-1:0] sw_price,
    input  logic [QTY_W-1:0]   sw_qty,
    input  logic               order_ready,
    output logic               order_valid,
    output logic               order_side,
    output logic [PRICE_W-1:0] order_price,
    output logic [QTY_W-1:0]   order_qty,
    output logic [ID_W-1:0]    order_id,
    output logic               side_sel,
    output logic               busy,
    output logic               reject_pulse,
    output logic [CNT_W-1:0]   reject_count,
    output logic [CNT_W-1:0]   drop_count
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              submit_prev;
    logic              side_prev;
    logic              submit_rise;
    logic              side_rise;
    logic              fields_bad;
    logic              accept;
    logic              reject;
    logic              drop;
    logic              done;
    logic [ID_W-1:0]   next_id;

    assign submit_rise = submit_clean & ~submit_prev;
    assign side_rise   = side_clean & ~side_prev;
    assign fields_bad  = (sw_qty == '0) || (sw_price > PRICE_W'(MAX_PRICE));
    assign order_valid = (state == SEND);
    assign busy        = (state == SEND);

    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A submit rise during SEND, including the cycle the transfer completes, is dropped.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        reject     = 1'b0;
        drop       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (submit_rise) begin
                    if (fields_bad) begin
                        reject = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        state_next = SEND;
                    end
                end
            end
            SEND: begin
                if (submit_rise) begin
                    drop = 1'b1;
                end
                if (order_ready) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Prev-level registers load the live levels in reset so a held button gives no edge afterwards.
    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            submit_prev  <= submit_clean;
            side_prev    <= side_clean;
            side_sel     <= 1'b0;
            order_side   <= 1'b0;
            order_price  <= '0;
            order_qty    <= '0;
            order_id     <= '0;
            next_id      <= '0;
            reject_pulse <= 1'b0;
            reject_count <= '0;
            drop_count   <= '0;
        end else begin
            submit_prev  <= submit_clean;
            side_prev    <= side_clean;
            reject_pulse <= reject;
            if (side_rise) begin
                side_sel <= ~side_sel;
            end
            if (accept) begin
                order_side  <= side_sel;
                order_price <= sw_price;
                order_qty   <= sw_qty;
                order_id    <= next_id;
            end
            if (done) begin
                next_id <= next_id + 1'b1;
            end
            if (reject && (reject_count != '1)) begin
                reject_count <= reject_count + 1'b1;
            end
            if (drop && (drop_count != '1)) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_manual_order_entry.sv
// Directed bench for manual_order_entry; expected orders are queued when a submit is
// driven and compared when the DUT completes a valid/ready transfer.
module tb_manual_order_entry;

    typedef struct packed {
        logic        side;
        logic [15:0] price;
        logic [7:0]  qty;
        logic [7:0]  id;
    } ord_t;

    logic        clk = 1'b0;
    logic        reset_in;
    logic        submit_clean;
    logic        side_clean;
    logic [15:0] sw_price;
    logic [7:0]  sw_qty;
    logic        order_ready;
    logic        order_valid;
    logic        order_side;
    logic [15:0] order_price;
    logic [7:0]  order_qty;
    logic [7:0]  order_id;
    logic        side_sel;
    logic        busy;
    logic        reject_pulse;
    logic [7:0]  reject_count;
    logic [7:0]  drop_count;

    int   ntests = 0;
    int   nfail  = 0;
    ord_t sb[$];
    logic exp_side;
    logic valid_seen;

    always #5 clk = ~clk;

    manual_order_entry #(
        .PRICE_W  (16),
        .QTY_W    (8),
        .ID_W     (8),
        .MAX_PRICE(10000),
        .CNT_W    (8)
    ) dut (
        .clock_in    (clk),
        .reset_in    (reset_in),
        .submit_clean(submit_clean),
        .side_clean  (side_clean),
        .sw_price    (sw_price),
        .sw_qty      (sw_qty),
        .order_ready (order_ready),
        .order_valid (order_valid),
        .order_side  (order_side),
        .order_price (order_price),
        .order_qty   (order_qty),
        .order_id    (order_id),
        .side_sel    (side_sel),
        .busy        (busy),
        .reject_pulse(reject_pulse),
        .reject_count(reject_count),
        .drop_count  (drop_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic s, input logic [15:0] p, input logic [7:0] q, input logic [7:0] i);
        ord_t o;
        o.side  = s;
        o.price = p;
        o.qty   = q;
        o.id    = i;
        sb.push_back(o);
    endtask

    // Scoreboard: every completed handshake must match the oldest queued order.
    always @(negedge clk) begin
        if (reset_in === 1'b1 && order_valid === 1'b1 && order_ready === 1'b1) begin
            ord_t got;
            ord_t exp;
            got = {order_side, order_price, order_qty, order_id};
            ntests++;
            if (sb.size() == 0) begin
                nfail++;
                $error("FAIL sb_unexpected observed=%0h expected=none", got);
            end else begin
                exp = sb.pop_front();
                assert (got === exp) else begin
                    nfail++;
                    $error("FAIL sb_order observed=%0h expected=%0h", got, exp);
                end
            end
        end
    end

    initial begin
        reset_in     = 1'b0;
        submit_clean = 1'b1;
        side_clean   = 1'b0;
        sw_price     = 16'd100;
        sw_qty       = 8'd5;
        order_ready  = 1'b0;
        exp_side     = 1'b0;
        repeat (3) tick();
        check("rst_valid", order_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_side_sel", side_sel, 0);
        check("rst_id", order_id, 0);
        check("rst_reject_pulse", reject_pulse, 0);

        // submit held through reset release must not create an order
        reset_in   = 1'b1;
        valid_seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (order_valid) valid_seen = 1'b1;
        end
        check("held_no_valid", valid_seen, 0);
        check("held_drop", drop_count, 0);
        check("held_reject", reject_count, 0);
        submit_clean = 1'b0;
        tick();

        // buy 100x5, ready withheld for four valid cycles
        push(1'b0, 16'd100, 8'd5, 8'd0);
        submit_clean = 1'b1;
        tick();
        check("n1_valid", order_valid, 1);
        check("n1_busy", busy, 1);
        submit_clean = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_valid", order_valid, 1);
            check("hold_price", order_price, 100);
            check("hold_qty", order_qty, 5);
        end
        order_ready = 1'b1;
        tick();
        check("xfer_valid_low", order_valid, 0);
        check("xfer_busy_low", busy, 0);
        check("retain_price", order_price, 100);

        // side toggle, then submit with ready tied high
        side_clean = 1'b1;
        tick();
        side_clean = 1'b0;
        tick();
        check("toggle_side_sel", side_sel, 1);
        exp_side = 1'b1;
        push(exp_side, 16'd100, 8'd5, 8'd1);
        submit_clean = 1'b1;
        tick();
        check("onecyc_valid", order_valid, 1);
        submit_clean = 1'b0;
        tick();
        check("onecyc_valid_low", order_valid, 0);

        // side rise coincident with submit rise latches the pre-toggle side
        push(exp_side, 16'd100, 8'd5, 8'd2);
        side_clean   = 1'b1;
        submit_clean = 1'b1;
        tick();
        exp_side = 1'b0;
        check("same_cyc_side_sel", side_sel, 0);
        check("same_cyc_order_side", order_side, 1);
        side_clean   = 1'b0;
        submit_clean = 1'b0;
        tick();

        // rejects: qty zero, price above max
        sw_qty = 8'd0;
        submit_clean = 1'b1;
        tick();
        check("rej_qty_pulse", reject_pulse, 1);
        check("rej_qty_no_valid", order_valid, 0);
        submit_clean = 1'b0;
        tick();
        check("rej_pulse_one_cycle", reject_pulse, 0);
        sw_qty   = 8'd5;
        sw_price = 16'd10001;
        submit_clean = 1'b1;
        tick();
        check("rej_price_pulse", reject_pulse, 1);
        check("rej_price_no_valid", order_valid, 0);
        submit_clean = 1'b0;
        tick();
        check("rej_count_2", reject_count, 2);

        // price exactly at the maximum is accepted
        sw_price = 16'd10000;
        push(exp_side, 16'd10000, 8'd5, 8'd3);
        submit_clean = 1'b1;
        tick();
        check("max_price_valid", order_valid, 1);
        check("max_price_no_reject", reject_pulse, 0);
        submit_clean = 1'b0;
        tick();

        // drops while in SEND, last one on the transfer cycle
        order_ready = 1'b0;
        sw_price = 16'd250;
        sw_qty   = 8'd9;
        push(exp_side, 16'd250, 8'd9, 8'd4);
        submit_clean = 1'b1;
        tick();
        submit_clean = 1'b0;
        sw_price = 16'd777;
        sw_qty   = 8'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            submit_clean = 1'b1;
            tick();
            submit_clean = 1'b0;
        end
        tick();
        check("drop_count_3", drop_count, 3);
        check("drop_busy", busy, 1);
        check("drop_price_kept", order_price, 250);
        check("drop_qty_kept", order_qty, 9);
        check("drop_no_reject", reject_count, 2);
        order_ready  = 1'b1;
        submit_clean = 1'b1;
        tick();
        check("drop_on_xfer", drop_count, 4);
        check("drop_xfer_idle", busy, 0);
        submit_clean = 1'b0;
        tick();

        // reject counter saturation
        sw_qty = 8'd0;
        for (int i = 0; i < 300; i++) begin
            submit_clean = 1'b1;
            tick();
            submit_clean = 1'b0;
            tick();
        end
        check("reject_saturate", reject_count, 255);

        // fresh reset, then 257 orders to observe ID wrap
        reset_in = 1'b0;
        tick();
        reset_in = 1'b1;
        tick();
        check("rst2_reject", reject_count, 0);
        check("rst2_drop", drop_count, 0);
        exp_side = 1'b0;
        sw_qty   = 8'd3;
        sw_price = 16'd42;
        order_ready = 1'b1;
        for (int i = 0; i < 257; i++) begin
            push(exp_side, 16'd42, 8'd3, 8'(i));
            submit_clean = 1'b1;
            tick();
            submit_clean = 1'b0;
            tick();
        end
        check("wrap_last_id", order_id, 0);

        // reset during SEND abandons the order and clears the ID
        order_ready  = 1'b0;
        submit_clean = 1'b1;
        tick();
        submit_clean = 1'b0;
        check("midsend_valid", order_valid, 1);
        check("midsend_id", order_id, 1);
        reset_in = 1'b0;
        tick();
        check("midsend_rst_valid", order_valid, 0);
        check("midsend_rst_id", order_id, 0);
        reset_in    = 1'b1;
        order_ready = 1'b1;
        tick();
        push(1'b0, 16'd42, 8'd3, 8'd0);
        submit_clean = 1'b1;
        tick();
        submit_clean = 1'b0;
        tick();
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
